fir_mac_ctrl: RTL

Sequencer and accumulator stage directly upstream of the filter ALU. Accepts input samples over a valid/ready handshake and stores them in a circular delay line. For each sample it issues one multiply-accumulate command per tap to the combinational ALU, registers the ALU result as the accumulator, then issues ALU_SATA and presents the saturated DATABITS result on a valid/ready output.

---
 rtl/myfilter_pkg.sv | 28 ++
 rtl/fir_mac_ctrl_if.sv | 38 +++
 rtl/fir_delay_line.sv | 62 ++++++
 rtl/fir_mac_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared filter definitions: data/accumulator widths, ALU command encoding,
// controller state encoding and the rounding constant.
package myfilter_pkg;

    localparam int unsigned DATABITS = 16;
    localparam int unsigned ACCBITS  = 40;

    typedef enum logic [1:0] {
        ALU_NOP,
        ALU_MU,
        ALU_ADMU,
        ALU_SATA
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT,
        OUT
    } ctrl_state_t;

    // Half an output LSB in accumulator scale; seeding the accumulator with
    // this turns the ALU's truncating saturate into round-to-nearest.
    function automatic logic [ACCBITS-1:0] round_const();
        round_const = ACCBITS'(1) << (DATABITS - 2);
    endfunction

endpackage

// File: rtl/fir_mac_ctrl_if.sv
// Bundle of the sample input stream, filtered output stream, coefficient
// write port and the operand/command/result bus to the filter ALU.
// slave: the controller side. master: the surrounding system side.
interface fir_mac_ctrl_if
    import myfilter_pkg::*;
#(
    parameter int unsigned TAPS     = 8,
    parameter int unsigned DATABITS = myfilter_pkg::DATABITS,
    parameter int unsigned ACCBITS  = myfilter_pkg::ACCBITS
);
    localparam int unsigned AW = $clog2(TAPS);

    logic [DATABITS-1:0] din;
    logic                din_valid;
    logic                din_ready;
    logic                coef_wr;
    logic [AW-1:0]       coef_addr;
    logic [DATABITS-1:0] coef_data;
    logic [DATABITS-1:0] dout;
    logic                dout_valid;
    logic                dout_ready;
    logic [DATABITS-1:0] m1_out;
    logic [DATABITS-1:0] m2_out;
    alu_cmd_t            cmd_out;
    logic [ACCBITS-1:0]  acc_out;
    logic [ACCBITS-1:0]  alu_d_in;

    modport slave (
        input  din, din_valid, coef_wr, coef_addr, coef_data, dout_ready, alu_d_in,
        output din_ready, dout, dout_valid, m1_out, m2_out, cmd_out, acc_out
    );

    modport master (
        output din, din_valid, coef_wr, coef_addr, coef_data, dout_ready, alu_d_in,
        input  din_ready, dout, dout_valid, m1_out, m2_out, cmd_out, acc_out
    );

endinterface

// File: rtl/fir_delay_line.sv
// Circular sample buffer. wr_en stores a sample at the write pointer;
// adv steps the pointer (wrapping TAPS-1 -> 0). rd_data returns the sample
// rd_off positions behind the write pointer, combinationally.
module fir_delay_line #(
    parameter int unsigned TAPS     = 8,
    parameter int unsigned DATABITS = 16,
    localparam int unsigned AW      = $clog2(TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATABITS-1:0] wr_data,
    input  logic                adv,
    input  logic [AW-1:0]       rd_off,
    output logic [DATABITS-1:0] rd_data
);
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);

    logic [DATABITS-1:0] line_q [TAPS];
    logic [DATABITS-1:0] line_d [TAPS];
    logic [AW-1:0]       wptr_q;
    logic [AW-1:0]       wptr_d;
    logic [AW-1:0]       rd_idx;

    // Next-state for buffer contents and write pointer.
    always_comb begin
        line_d = line_q;
        wptr_d = wptr_q;
        if (wr_en) begin
            line_d[wptr_q] = wr_data;
        end
        if (adv) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
        end
    end

    // Read index (wptr - rd_off) mod TAPS; also valid for non-power-of-2 TAPS.
    always_comb begin
        if (wptr_q >= rd_off) begin
            rd_idx = wptr_q - rd_off;
        end else begin
            rd_idx = AW'(TAPS_W + {1'b0, wptr_q} - {1'b0, rd_off});
        end
    end

    assign rd_data = line_q[rd_idx];

    // Buffer and pointer registers; reset clears all stored samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
            end
            wptr_q <= '0;
        end else begin
            line_q <= line_d;
            wptr_q <= wptr_d;
        end
    end

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR sequencer/accumulator feeding the combinational filter ALU.
// One sample in -> TAPS multiply-accumulate commands -> one saturate command
// -> one saturated sample out on a valid/ready port.
// Build option: define MYFILTER_ROUND_EN to seed the first MAC with half an
// output LSB so the ALU saturate rounds to nearest instead of truncating.
module fir_mac_ctrl
    import myfilter_pkg::*;
#(
    parameter int unsigned TAPS     = 8,
    parameter int unsigned DATABITS = myfilter_pkg::DATABITS,
    parameter int unsigned ACCBITS  = myfilter_pkg::ACCBITS
) (
    input logic          clk,
    input logic          rst,
    fir_mac_ctrl_if.slave bus
);
    localparam int unsigned   AW     = $clog2(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);

    ctrl_state_t         state_q, state_d;
    logic [AW-1:0]       k_q, k_d;
    logic [ACCBITS-1:0]  acc_q, acc_d;
    logic [DATABITS-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                din_ready_q, din_ready_d;
    logic [DATABITS-1:0] coef_q [TAPS];
    logic [DATABITS-1:0] coef_d [TAPS];

    logic                dl_wr_en;
    logic                dl_adv;
    logic [DATABITS-1:0] dl_rd_data;

    alu_cmd_t            cmd;
    logic [DATABITS-1:0] m1;
    logic [DATABITS-1:0] m2;
    logic [ACCBITS-1:0]  acc_o;

    fir_delay_line #(
        .TAPS     (TAPS),
        .DATABITS (DATABITS)
    ) u_line (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dl_wr_en),
        .wr_data (bus.din),
        .adv     (dl_adv),
        .rd_off  (k_q),
        .rd_data (dl_rd_data)
    );

    // Sequencer: next state, ALU operands/command and output register updates.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        coef_d       = coef_q;
        dl_wr_en     = 1'b0;
        dl_adv       = 1'b0;
        cmd          = ALU_NOP;
        m1           = '0;
        m2           = '0;
        acc_o        = '0;

        case (state_q)
            IDLE: begin
                if (bus.coef_wr && ({1'b0, bus.coef_addr} < TAPS_W)) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (bus.din_valid && din_ready_q) begin
                    dl_wr_en = 1'b1;
                    k_d      = '0;
                    state_d  = MAC;
                end
            end

            MAC: begin
                m1    = dl_rd_data;
                m2    = coef_q[k_q];
                acc_d = bus.alu_d_in;
                if (k_q == '0) begin
`ifdef MYFILTER_ROUND_EN
                    cmd   = ALU_ADMU;
                    acc_o = ACCBITS'(round_const());
`else
                    cmd   = ALU_MU;
                    acc_o = '0;
`endif
                end else begin
                    cmd   = ALU_ADMU;
                    acc_o = acc_q;
                end
                if (k_q == LAST) begin
                    k_d     = '0;
                    dl_adv  = 1'b1;
                    state_d = SAT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            SAT: begin
                cmd          = ALU_SATA;
                acc_o        = acc_q;
                dout_d       = bus.alu_d_in[DATABITS-1:0];
                dout_valid_d = 1'b1;
                state_d      = OUT;
            end

            OUT: begin
                if (bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready: low out of reset, then tracks the IDLE state.
        din_ready_d = (state_d == IDLE);
    end

    // Controller state, accumulator, coefficient bank and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= din_ready_d;
            coef_q       <= coef_d;
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.cmd_out    = cmd;
    assign bus.m1_out     = m1;
    assign bus.m2_out     = m2;
    assign bus.acc_out    = acc_o;

endmodule
